// File: rtl/despachante_ativos_if.sv
// Bus bundle between the active-node dispatcher and its evaluator/expander.
// The dispatcher uses the master modport; the evaluator and expander
// side (or a testbench) uses the slave modport.
interface despachante_ativos_if #(
   parameter int NUM_NA          = 4,
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4
);
   // evaluator side: slot status
   logic [NUM_NA-1:0]                 aa_aprovado_in;
   logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in;
   logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in;
   logic                              aa_tem_ativo_in;
   // evaluator side: command bus
   logic                              desativar_out;
   logic                              atualizar_out;
   logic [ADDR_WIDTH-1:0]             endereco_out;
   logic [CUSTO_WIDTH-1:0]            menor_vizinho_out;
   logic [DISTANCIA_WIDTH-1:0]        distancia_out;
   logic [ADDR_WIDTH-1:0]             anterior_out;
   // expander side: node handshake
   logic                              da_valido_out;
   logic [ADDR_WIDTH-1:0]             da_endereco_out;
   logic [DISTANCIA_WIDTH-1:0]        da_distancia_out;
   logic                              exp_pronto_in;
   // expander side: neighbour channel
   logic                              viz_valido_in;
   logic [ADDR_WIDTH-1:0]             viz_endereco_in;
   logic [CUSTO_WIDTH-1:0]            viz_custo_in;
   logic [DISTANCIA_WIDTH-1:0]        viz_distancia_in;
   logic                              da_viz_aceito_out;
   logic                              exp_fim_in;
   // status
   logic                              da_vazio_out;
   logic                              da_ocupado_out;

   modport master (
      input  aa_aprovado_in, aa_endereco_in, aa_distancia_in, aa_tem_ativo_in,
      output desativar_out, atualizar_out, endereco_out, menor_vizinho_out,
             distancia_out, anterior_out,
      output da_valido_out, da_endereco_out, da_distancia_out,
      input  exp_pronto_in,
      input  viz_valido_in, viz_endereco_in, viz_custo_in, viz_distancia_in,
      output da_viz_aceito_out,
      input  exp_fim_in,
      output da_vazio_out, da_ocupado_out
   );

   modport slave (
      output aa_aprovado_in, aa_endereco_in, aa_distancia_in, aa_tem_ativo_in,
      input  desativar_out, atualizar_out, endereco_out, menor_vizinho_out,
             distancia_out, anterior_out,
      input  da_valido_out, da_endereco_out, da_distancia_out,
      output exp_pronto_in,
      output viz_valido_in, viz_endereco_in, viz_custo_in, viz_distancia_in,
      input  da_viz_aceito_out,
      output exp_fim_in,
      input  da_vazio_out, da_ocupado_out
   );
endinterface

// File: rtl/despachante_ativos.sv
// Active-node dispatcher: picks approved slots round-robin, deactivates the
// chosen node, offers it to the expander and forwards each accepted
// neighbour to the evaluator as a one-cycle update command.
// Optional feature: define DESPACHANTE_CONTADOR_EN to add the 16-bit
// saturating expansion counter output da_num_expansoes_out.
module despachante_ativos #(
   parameter int NUM_NA          = 4,
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4
) (
   input  logic clk,
   input  logic rst_n,
`ifdef DESPACHANTE_CONTADOR_EN
   output logic [15:0] da_num_expansoes_out,
`endif
   despachante_ativos_if.master bus
);
   localparam int PTR_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

   typedef enum logic [1:0] {OCIOSO, DESATIVAR, ENTREGAR, EXPANDIR} estado_t;

   estado_t                    r_estado, w_prox;
   logic [PTR_W-1:0]           r_ptr;
   logic [PTR_W-1:0]           w_sel;
   logic                       w_achou;
   logic [ADDR_WIDTH-1:0]      r_end_no;
   logic [DISTANCIA_WIDTH-1:0] r_dist_no;
   logic                       r_aceito_ant;
   logic                       r_pend;
   logic                       r_fim_pend;
   logic [ADDR_WIDTH-1:0]      r_viz_end;
   logic [CUSTO_WIDTH-1:0]     r_viz_custo;
   logic [DISTANCIA_WIDTH-1:0] r_viz_dist;
   logic                       w_aceita;
   logic                       w_fim;

   // A neighbour is accepted only in EXPANDIR, never right after another
   // acceptance and never once the end of expansion has been flagged.
   assign w_aceita = (r_estado == EXPANDIR) && bus.viz_valido_in &&
                     !r_aceito_ant && !r_fim_pend;
   assign w_fim    = (r_estado == EXPANDIR) && (bus.exp_fim_in || r_fim_pend);

   // Round-robin search: first approved slot starting just after r_ptr
   always_comb begin
      logic [PTR_W-1:0] idx;
      w_achou = 1'b0;
      w_sel   = '0;
      idx     = '0;
      for (int j = 0; j < NUM_NA; j++) begin
         idx = PTR_W'((int'(r_ptr) + 1 + j) % NUM_NA);
         if (!w_achou && bus.aa_aprovado_in[idx]) begin
            w_achou = 1'b1;
            w_sel   = idx;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_estado <= OCIOSO;
      else        r_estado <= w_prox;
   end

   // Next-state logic; EXPANDIR stays while a neighbour is being accepted so
   // its update pulse issues before returning to OCIOSO
   always_comb begin
      w_prox = r_estado;
      unique case (r_estado)
         OCIOSO:    if (w_achou) w_prox = DESATIVAR;
         DESATIVAR: w_prox = ENTREGAR;
         ENTREGAR:  if (bus.exp_pronto_in) w_prox = EXPANDIR;
         EXPANDIR:  if (w_fim && !w_aceita) w_prox = OCIOSO;
         default:   w_prox = OCIOSO;
      endcase
   end

   // Node latch and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= PTR_W'(NUM_NA - 1);
         r_end_no  <= '0;
         r_dist_no <= '0;
      end else if (r_estado == OCIOSO && w_achou) begin
         r_ptr     <= w_sel;
         r_end_no  <= bus.aa_endereco_in[ADDR_WIDTH*int'(w_sel) +: ADDR_WIDTH];
         r_dist_no <= bus.aa_distancia_in[DISTANCIA_WIDTH*int'(w_sel) +: DISTANCIA_WIDTH];
      end
   end

   // Neighbour capture: accepted data becomes an update pulse next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aceito_ant <= 1'b0;
         r_pend       <= 1'b0;
         r_fim_pend   <= 1'b0;
         r_viz_end    <= '0;
         r_viz_custo  <= '0;
         r_viz_dist   <= '0;
      end else begin
         r_aceito_ant <= w_aceita;
         r_pend       <= w_aceita;
         r_fim_pend   <= w_aceita && bus.exp_fim_in;
         if (w_aceita) begin
            r_viz_end   <= bus.viz_endereco_in;
            r_viz_custo <= bus.viz_custo_in;
            r_viz_dist  <= bus.viz_distancia_in;
         end
      end
   end

`ifdef DESPACHANTE_CONTADOR_EN
   logic [15:0] r_num_exp;
   // Saturating count of ENTREGAR handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_num_exp <= '0;
      else if (r_estado == ENTREGAR && bus.exp_pronto_in && r_num_exp != 16'hFFFF)
         r_num_exp <= r_num_exp + 16'd1;
   end
   assign da_num_expansoes_out = r_num_exp;
`endif

   logic                       w_desativar;
   logic [ADDR_WIDTH-1:0]      w_endereco;
   logic [CUSTO_WIDTH-1:0]     w_menor;
   logic [DISTANCIA_WIDTH-1:0] w_distancia;
   logic [ADDR_WIDTH-1:0]      w_anterior;
   logic                       w_valido;

   // Outputs; command data is forced to 0 whenever no strobe is active
   always_comb begin
      w_desativar = (r_estado == DESATIVAR);
      w_valido    = (r_estado == ENTREGAR);
      w_endereco  = '0;
      w_menor     = '0;
      w_distancia = '0;
      w_anterior  = '0;
      if (w_desativar) begin
         w_endereco = r_end_no;
      end else if (r_pend) begin
         w_endereco  = r_viz_end;
         w_menor     = r_viz_custo;
         w_distancia = r_viz_dist;
         w_anterior  = r_end_no;
      end
   end

   assign bus.desativar_out     = w_desativar;
   assign bus.atualizar_out     = r_pend;
   assign bus.endereco_out      = w_endereco;
   assign bus.menor_vizinho_out = w_menor;
   assign bus.distancia_out     = w_distancia;
   assign bus.anterior_out      = w_anterior;
   assign bus.da_valido_out     = w_valido;
   assign bus.da_endereco_out   = w_valido ? r_end_no : '0;
   assign bus.da_distancia_out  = w_valido ? r_dist_no : '0;
   assign bus.da_viz_aceito_out = w_aceita;
   assign bus.da_vazio_out      = (r_estado == OCIOSO) && !bus.aa_tem_ativo_in &&
                                  !(|bus.aa_aprovado_in);
   assign bus.da_ocupado_out    = (r_estado != OCIOSO);
endmodule

// File: tb/tb_despachante_ativos.sv
// Testbench for despachante_ativos: table of dispatch vectors plus
// hand-written sequences for stall, neighbour streaming, end-of-expansion
// and reset in the middle of an expansion.
module tb_despachante_ativos;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   despachante_ativos_if #(.NUM_NA(4), .ADDR_WIDTH(5), .DISTANCIA_WIDTH(5), .CUSTO_WIDTH(4)) bus ();

`ifdef DESPACHANTE_CONTADOR_EN
   logic [15:0] num_exp;
`endif

   despachante_ativos #(.NUM_NA(4), .ADDR_WIDTH(5), .DISTANCIA_WIDTH(5), .CUSTO_WIDTH(4)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
`ifdef DESPACHANTE_CONTADOR_EN
      .da_num_expansoes_out (num_exp),
`endif
      .bus                  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   typedef struct {
      logic [3:0] ap;
      logic [4:0] e_end;
      logic [4:0] e_dist;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // From OCIOSO: apply approvals, walk DESATIVAR, stop inside ENTREGAR
   task automatic to_entregar(input logic [3:0] ap, input logic [4:0] e_end, input logic [4:0] e_dist);
      bus.aa_aprovado_in = ap;
      #1;
      chk("vazio_aprov", bus.da_vazio_out, 0);
      chk("ocupado_ocioso", bus.da_ocupado_out, 0);
      step();
      chk("desativar", bus.desativar_out, 1);
      chk("end_desativar", bus.endereco_out, e_end);
      chk("atualizar_desat", bus.atualizar_out, 0);
      chk("valido_desat", bus.da_valido_out, 0);
      chk("ocupado_desat", bus.da_ocupado_out, 1);
      step();
      chk("valido", bus.da_valido_out, 1);
      chk("da_end", bus.da_endereco_out, e_end);
      chk("da_dist", bus.da_distancia_out, e_dist);
      chk("desativar_once", bus.desativar_out, 0);
      chk("cmd_end_zero", bus.endereco_out, 0);
   endtask

   // From ENTREGAR: handshake, then end expansion without neighbours
   task automatic finish_exp();
      bus.exp_pronto_in = 1'b1;
      step();
      bus.exp_pronto_in = 1'b0;
      bus.exp_fim_in    = 1'b1;
      #1;
      chk("expandir_ocupado", bus.da_ocupado_out, 1);
      chk("aceito_sem_viz", bus.da_viz_aceito_out, 0);
      step();
      bus.exp_fim_in = 1'b0;
      chk("ocioso_apos_fim", bus.da_ocupado_out, 0);
      chk("atualizar_fim", bus.atualizar_out, 0);
   endtask

   initial begin
      tbl[0] = '{4'b0100, 5'd9,  5'd3};
      tbl[1] = '{4'b1000, 5'd30, 5'd31};
      tbl[2] = '{4'b1111, 5'd5,  5'd1};
      tbl[3] = '{4'b1111, 5'd7,  5'd2};
      tbl[4] = '{4'b1111, 5'd9,  5'd3};
      tbl[5] = '{4'b1111, 5'd30, 5'd31};
      tbl[6] = '{4'b1111, 5'd5,  5'd1};
      tbl[7] = '{4'b0001, 5'd5,  5'd1};
      tbl[8] = '{4'b0011, 5'd7,  5'd2};

      rst_n                = 1'b0;
      bus.aa_aprovado_in   = 4'b0000;
      bus.aa_endereco_in   = {5'd30, 5'd9, 5'd7, 5'd5};
      bus.aa_distancia_in  = {5'd31, 5'd3, 5'd2, 5'd1};
      bus.aa_tem_ativo_in  = 1'b0;
      bus.exp_pronto_in    = 1'b0;
      bus.viz_valido_in    = 1'b0;
      bus.viz_endereco_in  = '0;
      bus.viz_custo_in     = '0;
      bus.viz_distancia_in = '0;
      bus.exp_fim_in       = 1'b0;
      #1;
      chk("rst_desativar", bus.desativar_out, 0);
      chk("rst_atualizar", bus.atualizar_out, 0);
      chk("rst_endereco", bus.endereco_out, 0);
      chk("rst_valido", bus.da_valido_out, 0);
      chk("rst_aceito", bus.da_viz_aceito_out, 0);
      chk("rst_vazio", bus.da_vazio_out, 1);
      chk("rst_ocupado", bus.da_ocupado_out, 0);
`ifdef DESPACHANTE_CONTADOR_EN
      chk("rst_contador", num_exp, 0);
`endif
      step();
      step();
      rst_n = 1'b1;

      // Active nodes but nothing approved; stray expander inputs are ignored
      bus.aa_tem_ativo_in = 1'b1;
      bus.exp_pronto_in   = 1'b1;
      bus.viz_valido_in   = 1'b1;
      bus.exp_fim_in      = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("espera_vazio", bus.da_vazio_out, 0);
         chk("espera_ocupado", bus.da_ocupado_out, 0);
         chk("espera_aceito", bus.da_viz_aceito_out, 0);
         chk("espera_strobes", {bus.desativar_out, bus.atualizar_out, bus.da_valido_out}, 0);
      end
      bus.exp_pronto_in = 1'b0;
      bus.viz_valido_in = 1'b0;
      bus.exp_fim_in    = 1'b0;

      // Dispatch table: targeted slot, then round-robin with wrap-around
      for (int i = 0; i < 9; i++) begin
         to_entregar(tbl[i].ap, tbl[i].e_end, tbl[i].e_dist);
         finish_exp();
      end

      // Stall in ENTREGAR for 5 cycles; neighbour and end inputs ignored there
      to_entregar(4'b0101, 5'd9, 5'd3);
      bus.viz_valido_in = 1'b1;
      bus.exp_fim_in    = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("stall_valido", bus.da_valido_out, 1);
         chk("stall_end", bus.da_endereco_out, 9);
         chk("stall_dist", bus.da_distancia_out, 3);
         chk("stall_strobes", {bus.desativar_out, bus.atualizar_out}, 0);
         chk("stall_aceito", bus.da_viz_aceito_out, 0);
      end
      bus.viz_valido_in = 1'b0;
      bus.exp_fim_in    = 1'b0;
      bus.exp_pronto_in = 1'b1;
      step();
      bus.exp_pronto_in = 1'b0;

      // Three neighbours streamed back to back; end coincides with the last
      bus.viz_valido_in    = 1'b1;
      bus.viz_endereco_in  = 5'd1;
      bus.viz_custo_in     = 4'hF;
      bus.viz_distancia_in = 5'd10;
      #1;
      chk("viz1_aceito", bus.da_viz_aceito_out, 1);
      chk("viz1_sem_pulso", bus.atualizar_out, 0);
      step();
      chk("gap1_aceito", bus.da_viz_aceito_out, 0);
      chk("viz1_atualizar", bus.atualizar_out, 1);
      chk("viz1_end", bus.endereco_out, 1);
      chk("viz1_custo", bus.menor_vizinho_out, 4'hF);
      chk("viz1_dist", bus.distancia_out, 10);
      chk("viz1_anterior", bus.anterior_out, 9);
      bus.viz_endereco_in  = 5'd2;
      bus.viz_custo_in     = 4'd3;
      bus.viz_distancia_in = 5'd11;
      step();
      chk("viz2_aceito", bus.da_viz_aceito_out, 1);
      chk("viz2_sem_pulso", bus.atualizar_out, 0);
      chk("viz2_cmd_zero", bus.endereco_out, 0);
      step();
      chk("gap2_aceito", bus.da_viz_aceito_out, 0);
      chk("viz2_atualizar", bus.atualizar_out, 1);
      chk("viz2_end", bus.endereco_out, 2);
      chk("viz2_custo", bus.menor_vizinho_out, 3);
      chk("viz2_dist", bus.distancia_out, 11);
      chk("viz2_anterior", bus.anterior_out, 9);
      bus.viz_endereco_in  = 5'd3;
      bus.viz_custo_in     = 4'd0;
      bus.viz_distancia_in = 5'd31;
      step();
      bus.exp_fim_in = 1'b1;
      #1;
      chk("viz3_aceito", bus.da_viz_aceito_out, 1);
      step();
      bus.exp_fim_in      = 1'b0;
      bus.viz_valido_in   = 1'b0;
      bus.aa_aprovado_in  = 4'b0000;
      bus.aa_tem_ativo_in = 1'b0;
      chk("viz3_atualizar", bus.atualizar_out, 1);
      chk("viz3_end", bus.endereco_out, 3);
      chk("viz3_custo", bus.menor_vizinho_out, 0);
      chk("viz3_dist", bus.distancia_out, 31);
      chk("viz3_anterior", bus.anterior_out, 9);
      chk("viz3_desativar", bus.desativar_out, 0);
      chk("viz3_ocupado", bus.da_ocupado_out, 1);
      step();
      chk("fim_ocioso", bus.da_ocupado_out, 0);
      chk("fim_atualizar", bus.atualizar_out, 0);
      chk("fim_vazio", bus.da_vazio_out, 1);

      // Reset while a neighbour acceptance is pending
      bus.aa_tem_ativo_in = 1'b1;
      to_entregar(4'b0010, 5'd7, 5'd2);
      bus.exp_pronto_in = 1'b1;
      step();
      bus.exp_pronto_in   = 1'b0;
      bus.viz_valido_in   = 1'b1;
      bus.viz_endereco_in = 5'd4;
      #1;
      chk("rstm_aceito_antes", bus.da_viz_aceito_out, 1);
      rst_n = 1'b0;
      #1;
      chk("rstm_aceito", bus.da_viz_aceito_out, 0);
      chk("rstm_ocupado", bus.da_ocupado_out, 0);
      chk("rstm_vazio", bus.da_vazio_out, 0);
      step();
      chk("rstm_atualizar", bus.atualizar_out, 0);
      chk("rstm_cmd", {bus.desativar_out, bus.endereco_out, bus.anterior_out}, 0);
      chk("rstm_valido", bus.da_valido_out, 0);
      rst_n             = 1'b1;
      bus.viz_valido_in = 1'b0;
      to_entregar(4'b1111, 5'd5, 5'd1);
      finish_exp();
`ifdef DESPACHANTE_CONTADOR_EN
      chk("contador", num_exp, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/despachante_ativos.md
DESPACHANTE_ATIVOS -- requirements
Module: despachante_ativos

Interface
REQ-001 SHALL have parameters: NUM_NA, default 4, number of active-node slots; ADDR_WIDTH, default 5, node address width; DISTANCIA_WIDTH, default 5, distance width; CUSTO_WIDTH, default 4, edge-cost width.
REQ-002 SHALL use one clock and an asynchronous active-low reset, with the ports listed first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
REQ-003 SHALL have these evaluator-side inputs:
- aa_aprovado_in  in  NUM_NA  per-slot approved flags
- aa_endereco_in  in  ADDR_WIDTH*NUM_NA  slot addresses; slot i occupies bits [ADDR_WIDTH*i +: ADDR_WIDTH]
- aa_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  slot distances, packed the same way
- aa_tem_ativo_in  in  1  any slot active
REQ-004 SHALL drive this command bus to the evaluator:
- desativar_out  out  1  deactivate pulse
- atualizar_out  out  1  update pulse
- endereco_out  out  ADDR_WIDTH  command address
- menor_vizinho_out  out  CUSTO_WIDTH  command cost
- distancia_out  out  DISTANCIA_WIDTH  command distance
- anterior_out  out  ADDR_WIDTH  command predecessor
REQ-005 SHALL have this expander-side node handshake:
- da_valido_out  out  1  node offered
- da_endereco_out  out  ADDR_WIDTH  offered node address
- da_distancia_out  out  DISTANCIA_WIDTH  offered node distance
- exp_pronto_in  in  1  expander ready
REQ-006 SHALL have this expander-side neighbour channel:
- viz_valido_in  in  1  neighbour valid
- viz_endereco_in  in  ADDR_WIDTH  neighbour address
- viz_custo_in  in  CUSTO_WIDTH  neighbour cost
- viz_distancia_in  in  DISTANCIA_WIDTH  neighbour distance
- da_viz_aceito_out  out  1  neighbour accepted
- exp_fim_in  in  1  expansion finished, one-cycle pulse
REQ-007 SHALL have these status outputs:
- da_vazio_out  out  1  no active node remains
- da_ocupado_out  out  1  FSM not in OCIOSO

Function
REQ-008 SHALL implement FSM states OCIOSO, DESATIVAR, ENTREGAR and EXPANDIR.
REQ-009 In OCIOSO, if any aa_aprovado_in bit is set, the FSM SHALL select the first set index at or after (ptr+1) mod NUM_NA, latch that slot's address and distance, set ptr to the selected index, and go to DESATIVAR; ptr SHALL reset to NUM_NA-1.
REQ-010 In DESATIVAR, desativar_out SHALL be 1 for exactly one cycle with endereco_out equal to the latched address, then the FSM SHALL go to ENTREGAR.
REQ-011 In ENTREGAR, da_valido_out SHALL be 1 with stable da_endereco_out and da_distancia_out until a cycle in which exp_pronto_in is 1, then the FSM SHALL go to EXPANDIR.
REQ-012 In EXPANDIR, da_viz_aceito_out SHALL equal viz_valido_in except in the cycle immediately after an acceptance, when it SHALL be 0 (minimum one-cycle gap).
REQ-013 A neighbour accepted at cycle k SHALL produce atualizar_out=1 at cycle k+1, with endereco_out=viz_endereco, menor_vizinho_out=viz_custo, distancia_out=viz_distancia and anterior_out equal to the latched node address.
REQ-014 exp_fim_in in EXPANDIR SHALL return the FSM to OCIOSO after any pending atualizar pulse has issued; if exp_fim_in coincides with an accepted neighbour, that neighbour SHALL be forwarded first.
REQ-015 desativar_out and atualizar_out SHALL never both be 1 in the same cycle; the command data outputs SHALL be 0 whenever both are 0.
REQ-016 da_vazio_out SHALL be 1 exactly when the FSM is in OCIOSO, aa_tem_ativo_in=0 and no aa_aprovado_in bit is set.
REQ-017 In OCIOSO with aa_tem_ativo_in=1 and no approved slot, the FSM SHALL wait with all strobes at 0.
REQ-018 viz_valido_in and exp_fim_in SHALL be ignored outside EXPANDIR, and exp_pronto_in SHALL be ignored outside ENTREGAR.

Reset
REQ-019 Asserting rst_n low SHALL, at any time including mid-transaction, force the FSM to OCIOSO, ptr to NUM_NA-1, all latches to 0 and all outputs to 0 except da_vazio_out, which then follows REQ-016 (1 if no active node exists).

Configuration
REQ-020 When macro DESPACHANTE_CONTADOR_EN is defined, the block SHALL add output da_num_expansoes_out (16 bits, reset 0), which increments on each ENTREGAR handshake and saturates at 16'hFFFF; when the macro is undefined, the port and counter SHALL be absent.

Verification
REQ-021 Bench scenario: aprovado=4'b0100, slot 2 address=5'd9, distance=5'd3 -> desativar_out with endereco_out=9 one cycle later, then da_valido_out with 9/3.
REQ-022 Bench scenario: aprovado=4'b1111 held across four successive dispatches -> slots selected in order 0, 1, 2, 3; a fifth dispatch selects slot 0 (wrap-around).
REQ-023 Bench scenario: exp_pronto_in held 0 for 5 cycles in ENTREGAR -> da_valido_out and data stay stable, no command pulse is issued.
REQ-024 Bench scenario: viz_valido_in held 1 for 3 neighbours, addresses 1, 2, 3 -> da_viz_aceito_out toggles 1,0,1,0,1 and atualizar_out issues three pulses, each with anterior_out equal to the node address.
REQ-025 Bench scenario: exp_fim_in coincident with the last neighbour acceptance -> that atualizar pulse issues, then the FSM is in OCIOSO.
REQ-026 Bench scenario: rst_n pulsed low in EXPANDIR with a pending neighbour -> no atualizar pulse issues, outputs are 0, and the next dispatch starts from slot 0.
